// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, tag helpers and entry record for the reorder buffer slice.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 32;
    localparam int ENTRY_W  = 6;
    localparam int IDX_W    = $clog2(ROB_SIZE);

    // ENTRY_NULL sits one past the last real tag, so "no tag" needs no extra valid bit.
    localparam logic [ENTRY_W-1:0] ENTRY_NULL = ENTRY_W'(ROB_SIZE);

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pred_pc;
        logic [31:0] real_pc;
        logic        is_branch;
        logic        is_store;
    } rob_entry_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] value;
    } query_t;

    function automatic logic tag_valid(input entry_t t);
        return t < ENTRY_NULL;
    endfunction

    function automatic idx_t tag_idx(input entry_t t);
        return t[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, query, commit and flush signals between the ROB and its neighbours.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    // Strobes (get_instruction, alu/lsb_broadcast, commit_valid, roll_back) are
    // single-cycle valids; the only back-pressure is is_full_out, which gates
    // get_instruction, and a low rdy_in on the ROB freezes it entirely.
    logic        get_instruction;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [31:0] issue_pred_pc;
    logic        issue_is_branch;
    logic        issue_is_store;
    entry_t      rob_free_entry;
    logic        is_full_out;

    entry_t      query_j;
    entry_t      query_k;
    logic        query_j_ready;
    logic        query_k_ready;
    logic [31:0] query_j_value;
    logic [31:0] query_k_value;

    logic        alu_broadcast;
    entry_t      alu_entry;
    logic [31:0] alu_value;
    logic [31:0] alu_pc_out;
    logic        lsb_broadcast;
    entry_t      lsb_entry;
    logic [31:0] lsb_value;

    logic        commit_valid;
    entry_t      commit_entry;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        commit_store;
    logic        roll_back;
    logic [31:0] roll_back_pc;

    modport slave (
        input  get_instruction, issue_rd, issue_pc, issue_pred_pc, issue_is_branch, issue_is_store,
        output rob_free_entry, is_full_out,
        input  query_j, query_k,
        output query_j_ready, query_k_ready, query_j_value, query_k_value,
        input  alu_broadcast, alu_entry, alu_value, alu_pc_out, lsb_broadcast, lsb_entry, lsb_value,
        output commit_valid, commit_entry, commit_rd, commit_value, commit_store, roll_back, roll_back_pc
    );

    modport master (
        output get_instruction, issue_rd, issue_pc, issue_pred_pc, issue_is_branch, issue_is_store,
        input  rob_free_entry, is_full_out,
        output query_j, query_k,
        input  query_j_ready, query_k_ready, query_j_value, query_k_value,
        output alu_broadcast, alu_entry, alu_value, alu_pc_out, lsb_broadcast, lsb_entry, lsb_value,
        input  commit_valid, commit_entry, commit_rd, commit_value, commit_store, roll_back, roll_back_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB capture, in-order retire,
// mispredict flush at commit and operand forwarding for the dispatcher.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    reorder_buffer_if.slave  bus
);

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    rob_entry_t          ent [ROB_SIZE];
    idx_t                head;
    idx_t                tail;
    logic [IDX_W:0]      count;

    logic        commit_valid_q;
    entry_t      commit_entry_q;
    logic [4:0]  commit_rd_q;
    logic [31:0] commit_value_q;
    logic        commit_store_q;
    logic        roll_back_q;
    logic [31:0] roll_back_pc_q;

    logic   is_full;
    logic   do_issue;
    logic   commit_fire;
    logic   mispredict;
    idx_t   alu_idx;
    idx_t   lsb_idx;
    logic   alu_hit;
    logic   lsb_hit;
    query_t qj;
    query_t qk;

    assign is_full     = (count == (IDX_W+1)'(ROB_SIZE));
    assign do_issue    = bus.get_instruction && !is_full;
    assign alu_idx     = tag_idx(bus.alu_entry);
    assign lsb_idx     = tag_idx(bus.lsb_entry);
    assign alu_hit     = bus.alu_broadcast && tag_valid(bus.alu_entry) && busy[alu_idx];
    assign lsb_hit     = bus.lsb_broadcast && tag_valid(bus.lsb_entry) && busy[lsb_idx];
    // Retire decision uses the registered ready bit, so a CDB write to head lands first.
    assign commit_fire = busy[head] && ready[head];
    assign mispredict  = commit_fire && ent[head].is_branch &&
                         (ent[head].real_pc != ent[head].pred_pc);

    function automatic query_t lookup(input entry_t q);
        query_t r;
        idx_t   i;
        r = '0;
        i = tag_idx(q);
        if (tag_valid(q)) begin
            if (busy[i] && ready[i])
                r = '{ready: 1'b1, value: ent[i].value};
            else if (bus.alu_broadcast && bus.alu_entry == q)
                r = '{ready: 1'b1, value: bus.alu_value};
            else if (bus.lsb_broadcast && bus.lsb_entry == q)
                r = '{ready: 1'b1, value: bus.lsb_value};
        end
        return r;
    endfunction

    always_comb qj = lookup(bus.query_j);
    always_comb qk = lookup(bus.query_k);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy           <= '0;
            ready          <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commit_valid_q <= 1'b0;
            commit_entry_q <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_store_q <= 1'b0;
            roll_back_q    <= 1'b0;
            roll_back_pc_q <= '0;
        end else if (!rdy_in) begin
            commit_valid_q <= 1'b0;
            commit_store_q <= 1'b0;
            roll_back_q    <= 1'b0;
        end else begin
            commit_valid_q <= commit_fire;
            commit_store_q <= commit_fire && ent[head].is_store;
            roll_back_q    <= mispredict;

            // LSB first so that an illegal same-tag pair resolves to the ALU result.
            if (lsb_hit) begin
                ent[lsb_idx].value <= bus.lsb_value;
                ready[lsb_idx]     <= 1'b1;
            end
            if (alu_hit) begin
                ent[alu_idx].value   <= bus.alu_value;
                ent[alu_idx].real_pc <= bus.alu_pc_out;
                ready[alu_idx]       <= 1'b1;
            end

            if (commit_fire) begin
                busy[head]     <= 1'b0;
                ready[head]    <= 1'b0;
                commit_entry_q <= ENTRY_W'(head);
                commit_rd_q    <= ent[head].rd;
                commit_value_q <= ent[head].value;
            end

            if (mispredict) begin
                busy           <= '0;
                ready          <= '0;
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                roll_back_pc_q <= ent[head].real_pc;
            end else begin
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    // Fall-through PC seeds real_pc until an ALU result replaces it.
                    ent[tail]   <= '{rd:        bus.issue_rd,
                                     value:     32'd0,
                                     pred_pc:   bus.issue_pred_pc,
                                     real_pc:   bus.issue_pc + 32'd4,
                                     is_branch: bus.issue_is_branch,
                                     is_store:  bus.issue_is_store};
                    tail        <= tail + 1'b1;
                end
                if (commit_fire)
                    head <= head + 1'b1;
                count <= count + (IDX_W+1)'(do_issue) - (IDX_W+1)'(commit_fire);
            end
        end
    end

    assign bus.is_full_out    = is_full;
    assign bus.rob_free_entry = ENTRY_W'(tail);
    assign bus.query_j_ready  = qj.ready;
    assign bus.query_j_value  = qj.value;
    assign bus.query_k_ready  = qk.ready;
    assign bus.query_k_value  = qk.value;
    assign bus.commit_valid   = commit_valid_q;
    assign bus.commit_entry   = commit_entry_q;
    assign bus.commit_rd      = commit_rd_q;
    assign bus.commit_value   = commit_value_q;
    assign bus.commit_store   = commit_store_q;
    assign bus.roll_back      = roll_back_q;
    assign bus.roll_back_pc   = roll_back_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized checks of reorder_buffer against a program-order queue model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    int   errors = 0;
    int   checks = 0;

    reorder_buffer_if bus();

    reorder_buffer dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Model: in-flight instructions in program order, oldest first.
    typedef struct {
        logic [5:0]  tag;
        logic [4:0]  rd;
        logic [31:0] pred_pc;
        logic [31:0] real_pc;
        logic [31:0] value;
        bit          br;
        bit          st;
        bit          rdy;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_tail = 0;
    logic        e_cv = 0, e_cst = 0, e_rb = 0;
    logic [5:0]  e_ce = 0;
    logic [4:0]  e_crd = 0;
    logic [31:0] e_cval = 0, e_rbpc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input logic [5:0] t);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [32:0] m_query(input logic [5:0] q);
        int i;
        if (q >= ROB_SIZE) return 33'd0;
        i = m_find(q);
        if (i >= 0 && mq[i].rdy) return {1'b1, mq[i].value};
        if (bus.alu_broadcast && bus.alu_entry == q) return {1'b1, bus.alu_value};
        if (bus.lsb_broadcast && bus.lsb_entry == q) return {1'b1, bus.lsb_value};
        return 33'd0;
    endfunction

    task automatic model_step();
        bit     fire, full, rb;
        m_ent_t c, n;
        int     k;
        if (rst_in) begin
            mq.delete();
            m_tail = 0;
            e_cv = 0; e_cst = 0; e_rb = 0; e_ce = 0; e_crd = 0; e_cval = 0; e_rbpc = 0;
            return;
        end
        if (!rdy_in) begin
            e_cv = 0; e_cst = 0; e_rb = 0;
            return;
        end
        full = (mq.size() == ROB_SIZE);
        fire = (mq.size() > 0) && mq[0].rdy;
        if (fire) c = mq[0];
        rb = 0;
        if (bus.lsb_broadcast) begin
            k = m_find(bus.lsb_entry);
            if (k >= 0) begin mq[k].value = bus.lsb_value; mq[k].rdy = 1; end
        end
        if (bus.alu_broadcast) begin
            k = m_find(bus.alu_entry);
            if (k >= 0) begin
                mq[k].value = bus.alu_value; mq[k].real_pc = bus.alu_pc_out; mq[k].rdy = 1;
            end
        end
        e_cv = fire;
        e_cst = fire && c.st;
        e_rb = 0;
        if (fire) begin
            e_ce = c.tag; e_crd = c.rd; e_cval = c.value;
            void'(mq.pop_front());
            if (c.br && c.real_pc != c.pred_pc) begin
                e_rb = 1; e_rbpc = c.real_pc;
                mq.delete();
                m_tail = 0;
                rb = 1;
            end
        end
        if (!rb && bus.get_instruction && !full) begin
            n.tag = 6'(m_tail); n.rd = bus.issue_rd; n.pred_pc = bus.issue_pred_pc;
            n.real_pc = bus.issue_pc + 32'd4; n.value = 0;
            n.br = bus.issue_is_branch; n.st = bus.issue_is_store; n.rdy = 0;
            mq.push_back(n);
            m_tail = (m_tail + 1) % ROB_SIZE;
        end
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cycle();
        logic [32:0] rj, rk;
        #1;
        rj = m_query(bus.query_j);
        rk = m_query(bus.query_k);
        check("is_full_out", bus.is_full_out, mq.size() == ROB_SIZE);
        check("rob_free_entry", bus.rob_free_entry, m_tail);
        check("query_j_ready", bus.query_j_ready, rj[32]);
        check("query_j_value", bus.query_j_value, rj[31:0]);
        check("query_k_ready", bus.query_k_ready, rk[32]);
        check("query_k_value", bus.query_k_value, rk[31:0]);
        model_step();
        @(posedge clk_in);
        #1;
        check("commit_valid", bus.commit_valid, e_cv);
        check("commit_store", bus.commit_store, e_cst);
        check("roll_back", bus.roll_back, e_rb);
        if (e_cv) begin
            check("commit_entry", bus.commit_entry, e_ce);
            check("commit_rd", bus.commit_rd, e_crd);
            check("commit_value", bus.commit_value, e_cval);
        end
        if (e_rb) check("roll_back_pc", bus.roll_back_pc, e_rbpc);
        bus.get_instruction = 0;
        bus.alu_broadcast = 0;
        bus.lsb_broadcast = 0;
    endtask

    task automatic do_reset();
        rst_in = 1;
        cycle();
        check("rst_commit_entry", bus.commit_entry, 0);
        check("rst_commit_rd", bus.commit_rd, 0);
        check("rst_commit_value", bus.commit_value, 0);
        check("rst_roll_back_pc", bus.roll_back_pc, 0);
        check("rst_full", bus.is_full_out, 0);
        check("rst_free", bus.rob_free_entry, 0);
        rst_in = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pred,
                         input bit br, input bit st);
        bus.get_instruction = 1; bus.issue_rd = rd; bus.issue_pc = pc;
        bus.issue_pred_pc = pred; bus.issue_is_branch = br; bus.issue_is_store = st;
        cycle();
    endtask

    task automatic lsb_bc(input logic [5:0] t, input logic [31:0] v);
        bus.lsb_broadcast = 1; bus.lsb_entry = t; bus.lsb_value = v;
    endtask

    task automatic alu_bc(input logic [5:0] t, input logic [31:0] v, input logic [31:0] npc);
        bus.alu_broadcast = 1; bus.alu_entry = t; bus.alu_value = v; bus.alu_pc_out = npc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        int ia, il;
        int cand[$];
        bus.get_instruction = 0; bus.issue_rd = 0; bus.issue_pc = 0; bus.issue_pred_pc = 0;
        bus.issue_is_branch = 0; bus.issue_is_store = 0;
        bus.query_j = ENTRY_NULL; bus.query_k = ENTRY_NULL;
        bus.alu_broadcast = 0; bus.alu_entry = 0; bus.alu_value = 0; bus.alu_pc_out = 0;
        bus.lsb_broadcast = 0; bus.lsb_entry = 0; bus.lsb_value = 0;

        // Basic issue and in-order commit
        do_reset();
        issue(5'd1, 32'h0, 32'h4, 0, 0);
        issue(5'd2, 32'h4, 32'h8, 0, 0);
        issue(5'd3, 32'h8, 32'hc, 0, 0);
        check("t1_free_after3", bus.rob_free_entry, 3);
        lsb_bc(6'd1, 32'd7); cycle();
        check("t1_no_commit", bus.commit_valid, 0);
        lsb_bc(6'd0, 32'd5); cycle();
        cycle();
        check("t1_c0_valid", bus.commit_valid, 1);
        check("t1_c0_entry", bus.commit_entry, 0);
        check("t1_c0_value", bus.commit_value, 5);
        cycle();
        check("t1_c1_entry", bus.commit_entry, 1);
        check("t1_c1_value", bus.commit_value, 7);
        lsb_bc(6'd2, 32'd9); cycle();
        cycle(); cycle();

        // Fill, reject when full, wrap-around
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) issue(5'(i + 1), 32'(i * 4), 32'(i * 4 + 4), 0, 0);
        check("t2_full", bus.is_full_out, 1);
        check("t2_tail_wrap", bus.rob_free_entry, 0);
        issue(5'd9, 32'h100, 32'h104, 0, 0);
        check("t2_ignored_tail", bus.rob_free_entry, 0);
        lsb_bc(6'd0, 32'h11); cycle();
        cycle();
        check("t2_commit_tag0", bus.commit_entry, 0);
        check("t2_not_full", bus.is_full_out, 0);
        check("t2_wrap_tag", bus.rob_free_entry, 0);
        issue(5'd4, 32'h200, 32'h204, 0, 0);
        check("t2_refull", bus.is_full_out, 1);

        // Branch mispredict flush
        do_reset();
        issue(5'd1, 32'h0, 32'h10, 1, 0);
        issue(5'd2, 32'h4, 32'h8, 0, 0);
        issue(5'd3, 32'h8, 32'hc, 0, 0);
        lsb_bc(6'd1, 32'h1); alu_bc(6'd2, 32'h2, 32'hc); cycle();
        alu_bc(6'd0, 32'h4, 32'h20); cycle();
        cycle();
        check("t3_rb", bus.roll_back, 1);
        check("t3_rb_pc", bus.roll_back_pc, 32'h20);
        check("t3_cv", bus.commit_valid, 1);
        cycle();
        check("t3_rb_pulse", bus.roll_back, 0);
        check("t3_free0", bus.rob_free_entry, 0);
        check("t3_empty", bus.is_full_out, 0);
        cycle(); cycle();

        // Dual CDB with forwarding queries
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(i + 10), 32'(i * 4), 32'(i * 4 + 4), 0, 0);
        alu_bc(6'd2, 32'hAA, 32'hc); lsb_bc(6'd3, 32'hBB);
        bus.query_j = 6'd2; bus.query_k = 6'd3;
        #1;
        check("t4_qj_ready", bus.query_j_ready, 1);
        check("t4_qj_value", bus.query_j_value, 32'hAA);
        check("t4_qk_ready", bus.query_k_ready, 1);
        check("t4_qk_value", bus.query_k_value, 32'hBB);
        cycle();
        lsb_bc(6'd0, 32'h50); alu_bc(6'd1, 32'h51, 32'h8); cycle();
        cycle(); cycle();
        cycle();
        check("t4_c2_value", bus.commit_value, 32'hAA);
        cycle();
        check("t4_c3_value", bus.commit_value, 32'hBB);
        bus.query_j = ENTRY_NULL; bus.query_k = ENTRY_NULL;

        // Pause holds everything, then reset mid-stream
        issue(5'd7, 32'h40, 32'h44, 0, 0);
        lsb_bc(6'd4, 32'h77); cycle();
        rdy_in = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t5_pause_cv", bus.commit_valid, 0);
            check("t5_pause_tail", bus.rob_free_entry, 5);
        end
        rdy_in = 1;
        cycle();
        check("t5_resume_cv", bus.commit_valid, 1);
        check("t5_resume_val", bus.commit_value, 32'h77);
        issue(5'd8, 32'h48, 32'h4c, 0, 0);
        issue(5'd9, 32'h4c, 32'h50, 0, 0);
        do_reset();
        check("t5_rst_cv", bus.commit_valid, 0);

        // Store commit
        issue(5'd0, 32'h60, 32'h64, 0, 1);
        lsb_bc(6'd0, 32'h1234); cycle();
        cycle();
        check("t6_store", bus.commit_store, 1);
        check("t6_store_cv", bus.commit_valid, 1);
        check("t6_store_rd", bus.commit_rd, 0);
        cycle();
        check("t6_store_pulse", bus.commit_store, 0);

        // Randomized traffic
        for (int cyc = 0; cyc < 700; cyc++) begin
            rst_in = ($urandom_range(0, 299) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                bus.get_instruction = 1;
                bus.issue_is_store = ($urandom_range(0, 5) == 0);
                bus.issue_is_branch = !bus.issue_is_store && ($urandom_range(0, 3) == 0);
                bus.issue_rd = bus.issue_is_store ? 5'd0 : 5'($urandom_range(0, 31));
                bus.issue_pc = {$urandom_range(0, 16'hffff), 2'b00};
                bus.issue_pred_pc = {$urandom_range(0, 16'hffff), 2'b00};
            end
            cand.delete();
            for (int i = 0; i < mq.size(); i++) if (!mq[i].rdy) cand.push_back(i);
            ia = -1;
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                ia = cand[$urandom_range(0, cand.size() - 1)];
                alu_bc(mq[ia].tag, $urandom(),
                       (mq[ia].br && $urandom_range(0, 3) == 0) ? mq[ia].pred_pc + 32'd8 : mq[ia].pred_pc);
            end else if ($urandom_range(0, 7) == 0) begin
                alu_bc(ENTRY_NULL, $urandom(), $urandom());
            end
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                il = cand[$urandom_range(0, cand.size() - 1)];
                if (il != ia && !mq[il].br) lsb_bc(mq[il].tag, $urandom());
            end
            bus.query_j = 6'($urandom_range(0, ROB_SIZE));
            bus.query_k = 6'($urandom_range(0, ROB_SIZE));
            cycle();
        end
        rst_in = 0;
        rdy_in = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
